// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and widths.
// Used by the B-channel arbiter and its interface.
package axi_lite_pkg;

    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } bresp_e;

    // SLVERR and DECERR both carry bit 1 set.
    function automatic logic is_err(input logic [RESP_W-1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_lite_bresp_arbiter_if.sv
// Write-response bundle: N slave-side B channels plus the shared
// master-side B channel.
interface axi_lite_bresp_arbiter_if
    import axi_lite_pkg::*;
#(
    parameter int N_SLV = 4,
    parameter int IDX_W = $clog2(N_SLV)
);
    logic [N_SLV-1:0]        s_BVALID;
    logic [RESP_W*N_SLV-1:0] s_BRESP;
    logic [N_SLV-1:0]        s_BREADY;
    logic                    m_BVALID;
    logic [RESP_W-1:0]       m_BRESP;
    logic [IDX_W-1:0]        m_BID;
    logic                    m_BREADY;

    // Arbiter view: receives slave responses, drives the master.
    modport slave (
        input  s_BVALID, s_BRESP, m_BREADY,
        output s_BREADY, m_BVALID, m_BRESP, m_BID
    );

    // Environment view: slaves plus master, opposite directions.
    modport master (
        output s_BVALID, s_BRESP, m_BREADY,
        input  s_BREADY, m_BVALID, m_BRESP, m_BID
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after 'last',
// wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    // Scan last+1, last+2, ... and keep the first hit.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        int               pos;
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos  = (int'(last) + k) % N;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/axi_lite_bresp_arbiter.sv
// Shares one AXI4-Lite B channel among N_SLV slaves with a
// round-robin grant, one-entry output buffer and error counter.
module axi_lite_bresp_arbiter
    import axi_lite_pkg::*;
#(
    parameter int N_SLV    = 4,
    parameter int IDX_W    = $clog2(N_SLV),
    parameter int ERRCNT_W = 8
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    axi_lite_bresp_arbiter_if.slave bus,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_clr
);
    logic              any;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  last_grant;
    logic              load;
    logic              drain;
    logic [RESP_W-1:0] sel_resp;
    logic              out_valid;
    logic [RESP_W-1:0] out_resp;
    logic [IDX_W-1:0]  out_id;

    rr_arbiter #(
        .N     (N_SLV),
        .IDX_W (IDX_W)
    ) u_rr (
        .req  (bus.s_BVALID),
        .last (last_grant),
        .any  (any),
        .idx  (sel)
    );

    assign drain = out_valid && bus.m_BREADY;
    assign load  = any && (!out_valid || bus.m_BREADY);

    // Route the winner's response and handshake its ready.
    always_comb begin
        sel_resp     = '0;
        bus.s_BREADY = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_resp        = bus.s_BRESP[RESP_W*i +: RESP_W];
                bus.s_BREADY[i] = load;
            end
        end
    end

    // Output buffer: load overrides drain for back-to-back flow.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_valid  <= 1'b0;
            out_resp   <= '0;
            out_id     <= '0;
            last_grant <= IDX_W'(N_SLV - 1);
        end else if (load) begin
            out_valid  <= 1'b1;
            out_resp   <= sel_resp;
            out_id     <= sel;
            last_grant <= sel;
        end else if (drain) begin
            out_valid <= 1'b0;
            out_resp  <= '0;
        end
    end

    // Saturating count of error responses taken by the master.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (drain && is_err(out_resp) && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.m_BVALID = out_valid;
    assign bus.m_BRESP  = out_resp;
    assign bus.m_BID    = out_id;
endmodule

// File: doc/axi_lite_bresp_arbiter.md
Name: axi_lite_bresp_arbiter

Overview:
- Shares one AXI4-Lite write-response (B) channel toward the master among N_SLV slave-side B channels.
- Round-robin arbitration with a single-entry registered output buffer.
- Tags each forwarded response with the winning slave index.
- Counts error responses (SLVERR/DECERR) for status readback.
- Sits in the interconnect between the per-slave write-response logic and the master's write-response capture logic.

Parameters:
- N_SLV, 4, number of slave B channels; 2..16.
- IDX_W, $clog2(N_SLV), width of the grant index.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- ACLK  in  1  clock; all state updates on posedge.
- ARESETn  in  1  asynchronous active-low reset.
- s_BVALID  in  N_SLV  per-slave response valid.
- s_BRESP  in  2*N_SLV  per-slave response; slave i uses bits [2i+1:2i].
- s_BREADY  out  N_SLV  per-slave ready; one-hot or zero.
- m_BVALID  out  1  response valid toward master.
- m_BRESP  out  2  response toward master.
- m_BID  out  IDX_W  index of the slave whose response is presented.
- m_BREADY  in  1  master ready.
- err_cnt  out  ERRCNT_W  saturating count of error responses delivered.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (ARESETn=0, asynchronous):
  - m_BVALID=0, m_BRESP=2'b00, m_BID=0, err_cnt=0.
  - last_grant=N_SLV-1, so slave 0 has first priority after reset.
  - s_BREADY=0, because it is derived from m_BVALID=0 and the inputs.
- Buffer states:
  - EMPTY (m_BVALID=0).
  - FULL (m_BVALID=1).
  - The buffer is implied by m_BVALID; no separate state register.
- Load condition: load = |s_BVALID && (!m_BVALID || m_BREADY).
  - A drain and a load may occur in the same cycle, giving back-to-back throughput of 1 response/cycle.
- Selection (combinational):
  - sel = first i with s_BVALID[i]=1, searching last_grant+1, last_grant+2, ... modulo N_SLV.
- s_BREADY (combinational): s_BREADY[sel]=1 only when load=1; otherwise all zero.
  - Combinational path from m_BREADY to s_BREADY is permitted.
- Posedge with load:
  - m_BRESP<=s_BRESP[sel], m_BID<=sel, m_BVALID<=1, last_grant<=sel.
  - Latency: slave handshake to m_BVALID is 1 cycle.
- Posedge with m_BVALID && m_BREADY and no load: m_BVALID<=0, m_BRESP<=0, m_BID holds.
- FULL without m_BREADY: m_BVALID, m_BRESP and m_BID hold stable; no s_BREADY is asserted. This is AXI stability.
- No lock across cycles: arbitration is re-evaluated every cycle.
  - A slave dropping s_BVALID before its handshake is a protocol violation; the block stays consistent but the response is not forwarded.
- Error counter:
  - On each master handshake (m_BVALID && m_BREADY) with m_BRESP[1]=1 (2'b10 or 2'b11), err_cnt increments.
  - err_cnt saturates at all-ones.
  - err_clr has priority over an increment in the same cycle; the result is 0.
- Single requester: a continuously requesting slave is granted every load opportunity.
- Reset mid-operation: any buffered response is discarded, with no handshake to the master. Slaves re-present their responses after reset.

Decomposition:
- Shared package axi_lite_pkg:
  - BRESP encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - RESP_W=2.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs req[N-1:0] and last[IDX_W-1:0].
  - Outputs any and idx.
  - Purely combinational, reusable by the AW/AR channel arbiters.
- The buffer and counter stay in the top module.

Test Plan:
- Reset then idle: all s_BVALID=0 for 5 cycles -> m_BVALID=0, s_BREADY=0, err_cnt=0.
- Single response, master ready: s_BVALID=4'b0100, s_BRESP slot2=2'b00, m_BREADY=1.
  - Cycle 0: s_BREADY=4'b0100.
  - Cycle 1: m_BVALID=1, m_BRESP=00, m_BID=2.
  - Cycle 2: m_BVALID=0.
- Round-robin fairness: s_BVALID=4'b1111 held, m_BREADY=1 -> m_BID sequence 0,1,2,3,0 on consecutive cycles, each with one-hot s_BREADY.
- Backpressure: two slaves (1,3) valid, m_BREADY=0 for 4 cycles.
  - m_BID=1 and m_BRESP held stable; s_BREADY=0 after the first load.
  - Raise m_BREADY -> same-cycle s_BREADY=4'b1000; next cycle m_BID=3.
- Error counting: deliver responses 10, 11, 00, 01 -> err_cnt=2.
  - Preload err_cnt=255 then deliver SLVERR -> err_cnt stays 255.
  - err_clr coinciding with a DECERR handshake -> err_cnt=0.
- Async reset mid-transfer: m_BVALID=1, m_BREADY=0, assert ARESETn=0 between edges.
  - Outputs clear immediately (m_BVALID=0, m_BRESP=00).
  - After release with s_BVALID=4'b1001, first grant goes to slave 0.
